ddr_mux2_arbiter: RTL and testbench

//  Round-robin, burst-aware arbiter that shares the 2-input DDR datapath mux between two requesters.

---
 rtl/ddr_mux2_arbiter_pkg.sv | 23 ++
 rtl/ddr_mux2_arbiter.sv | 165 ++++++++++++++++
 tb/tb_ddr_mux2_arbiter.sv | 401 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ddr_mux2_arbiter_pkg.sv
// Shared types and helpers for the two-requester DDR mux arbiter.
package ddr_mux2_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_GNT0 = 2'b01,
    ST_GNT1 = 2'b10
  } arb_state_e;

  localparam int MAX_BURST_DEF = 16;
  localparam int TIMEOUT_DEF   = 64;

  // Bits needed to hold the value max_val (inclusive).
  function automatic int cnt_width(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

  // Grant state for requester idx.
  function automatic arb_state_e gnt_state(input logic idx);
    return idx ? ST_GNT1 : ST_GNT0;
  endfunction

endpackage

// File: rtl/ddr_mux2_arbiter.sv
// Round-robin, burst-aware arbiter driving the one-hot select of the
// 2-input DDR datapath mux. Bursts are locked to one requester until the
// last beat, the beat cap, or a mid-burst stall timeout.
//
//  state   | meaning
//  --------+------------------------------------------------------------
//  IDLE    | no grant; arbitrate this cycle, first beat the next cycle
//  GNT0    | requester 0 owns the mux; beats issue when req0 & dn_ready
//  GNT1    | requester 1 owns the mux; beats issue when req1 & dn_ready
module ddr_mux2_arbiter
  import ddr_mux2_arbiter_pkg::*;
#(
  parameter int MAX_BURST = MAX_BURST_DEF,
  parameter int CNT_W     = cnt_width(MAX_BURST),
  parameter int TIMEOUT   = TIMEOUT_DEF,
  parameter int TO_W      = cnt_width(TIMEOUT)
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_req0,
  input  logic             i_req1,
  input  logic             i_last0,
  input  logic             i_last1,
  input  logic             i_dn_ready,
  output logic [1:0]       o_sel_en,
  output logic             o_ack0,
  output logic             o_ack1,
  output logic             o_busy,
  output logic             o_owner,
  output logic [CNT_W-1:0] o_beat_cnt,
  output logic             o_err_timeout
);

  localparam logic [CNT_W-1:0] BEAT_LAST = CNT_W'(MAX_BURST - 1);
  localparam logic [TO_W-1:0]  TO_LAST   = TO_W'(TIMEOUT - 1);

  arb_state_e       r_state;
  arb_state_e       w_nxt_state;
  logic             r_last_served;
  logic             w_nxt_last_served;
  logic             r_owner;
  logic             w_nxt_owner;
  logic [CNT_W-1:0] r_beat_cnt;
  logic [CNT_W-1:0] w_nxt_beat_cnt;
  logic [TO_W-1:0]  r_to_cnt;
  logic [TO_W-1:0]  w_nxt_to_cnt;
  logic             r_err_timeout;
  logic             w_nxt_err_timeout;
  logic [1:0]       w_sel_en;

  logic             w_cur;
  logic             w_cur_req;
  logic             w_cur_last;
  logic             w_oth_req;
  logic             w_burst_full;
  logic             w_to_expired;

  // View of the inputs from the point of view of the current grant holder.
  always_comb begin
    w_cur        = (r_state == ST_GNT1);
    w_cur_req    = w_cur ? i_req1  : i_req0;
    w_oth_req    = w_cur ? i_req0  : i_req1;
    w_cur_last   = w_cur ? i_last1 : i_last0;
    w_burst_full = (r_beat_cnt == BEAT_LAST);
    w_to_expired = (r_to_cnt == TO_LAST);
  end

  // Next-state, counter updates and the combinational mux select.
  always_comb begin
    w_nxt_state       = r_state;
    w_nxt_last_served = r_last_served;
    w_nxt_beat_cnt    = r_beat_cnt;
    w_nxt_to_cnt      = r_to_cnt;
    w_nxt_err_timeout = 1'b0;
    w_sel_en          = 2'b00;

    case (r_state)
      ST_IDLE: begin
        // A tie goes to whoever was not served last.
        if (i_req0 && (!i_req1 || r_last_served)) begin
          w_nxt_state = ST_GNT0;
        end else if (i_req1) begin
          w_nxt_state = ST_GNT1;
        end
      end

      ST_GNT0, ST_GNT1: begin
        if (w_cur_req && i_dn_ready) begin
          w_sel_en     = w_cur ? 2'b10 : 2'b01;
          w_nxt_to_cnt = '0;
          if (w_cur_last || w_burst_full) begin
            // Tenure ends; hand straight over so the next cycle can issue.
            w_nxt_last_served = w_cur;
            w_nxt_beat_cnt    = '0;
            w_nxt_state       = w_oth_req ? gnt_state(!w_cur) : gnt_state(w_cur);
          end else begin
            w_nxt_beat_cnt = r_beat_cnt + CNT_W'(1);
          end
        end else if (!w_cur_req) begin
          // Stalled by the requester itself; back-pressure is not counted.
          if (w_to_expired) begin
            w_nxt_err_timeout = 1'b1;
            w_nxt_last_served = w_cur;
            w_nxt_beat_cnt    = '0;
            w_nxt_to_cnt      = '0;
            w_nxt_state       = w_oth_req ? gnt_state(!w_cur) : ST_IDLE;
          end else begin
            w_nxt_to_cnt = r_to_cnt + TO_W'(1);
          end
        end
      end

      default: begin
        w_nxt_state    = ST_IDLE;
        w_nxt_beat_cnt = '0;
        w_nxt_to_cnt   = '0;
      end
    endcase
  end

  // Owner follows entry into a grant state and holds through IDLE.
  always_comb begin
    w_nxt_owner = r_owner;
    if (w_nxt_state == ST_GNT0) begin
      w_nxt_owner = 1'b0;
    end else if (w_nxt_state == ST_GNT1) begin
      w_nxt_owner = 1'b1;
    end
  end

  // State register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_nxt_state;
    end
  end

  // Tenure bookkeeping registers; last_served resets to 1 so req0 wins the first tie.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_last_served <= 1'b1;
      r_owner       <= 1'b0;
      r_beat_cnt    <= '0;
      r_to_cnt      <= '0;
      r_err_timeout <= 1'b0;
    end else begin
      r_last_served <= w_nxt_last_served;
      r_owner       <= w_nxt_owner;
      r_beat_cnt    <= w_nxt_beat_cnt;
      r_to_cnt      <= w_nxt_to_cnt;
      r_err_timeout <= w_nxt_err_timeout;
    end
  end

  assign o_sel_en      = w_sel_en;
  assign o_ack0        = w_sel_en[0];
  assign o_ack1        = w_sel_en[1];
  assign o_busy        = (r_state != ST_IDLE);
  assign o_owner       = r_owner;
  assign o_beat_cnt    = r_beat_cnt;
  assign o_err_timeout = r_err_timeout;

endmodule

// File: tb/tb_ddr_mux2_arbiter.sv
// Self-checking bench for ddr_mux2_arbiter: directed scenarios plus a
// random soak, with a cycle model feeding a scoreboard at the mux output.
module tb_ddr_mux2_arbiter;

  localparam int MAXB = 16;
  localparam int TOUT = 64;
  localparam int CW   = 5;
  localparam int TW   = 7;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req0 = 1'b0, req1 = 1'b0;
  logic          last0 = 1'b0, last1 = 1'b0;
  logic          dn = 1'b0;
  logic [1:0]    sel_en;
  logic          ack0, ack1, busy, owner, err;
  logic [CW-1:0] beat_cnt;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  ddr_mux2_arbiter #(
    .MAX_BURST(MAXB),
    .CNT_W    (CW),
    .TIMEOUT  (TOUT),
    .TO_W     (TW)
  ) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_req0       (req0),
    .i_req1       (req1),
    .i_last0      (last0),
    .i_last1      (last1),
    .i_dn_ready   (dn),
    .o_sel_en     (sel_en),
    .o_ack0       (ack0),
    .o_ack1       (ack1),
    .o_busy       (busy),
    .o_owner      (owner),
    .o_beat_cnt   (beat_cnt),
    .o_err_timeout(err)
  );

  // ---------------- behavioural model ----------------
  typedef struct packed {
    logic [1:0] st;   // 0 idle, 1 grant0, 2 grant1
    logic       ls;
    logic       own;
    logic [4:0] cnt;
    logic [6:0] to;
    logic       err;
  } m_t;

  m_t m;

  function automatic m_t m_next(m_t s, logic r0, logic r1, logic l0, logic l1, logic d);
    m_t   n;
    logic i, ri, ro, li;
    n = s;
    n.err = 1'b0;
    if (s.st == 2'd0) begin
      if (r0 && (!r1 || s.ls)) n.st = 2'd1;
      else if (r1) n.st = 2'd2;
    end else begin
      i  = (s.st == 2'd2);
      ri = i ? r1 : r0;
      ro = i ? r0 : r1;
      li = i ? l1 : l0;
      if (ri && d) begin
        n.to = 7'd0;
        if (li || s.cnt == 5'(MAXB - 1)) begin
          n.ls  = i;
          n.cnt = 5'd0;
          if (ro) n.st = i ? 2'd1 : 2'd2;
        end else begin
          n.cnt = s.cnt + 5'd1;
        end
      end else if (!ri) begin
        if (s.to == 7'(TOUT - 1)) begin
          n.err = 1'b1;
          n.ls  = i;
          n.cnt = 5'd0;
          n.to  = 7'd0;
          n.st  = ro ? (i ? 2'd1 : 2'd2) : 2'd0;
        end else begin
          n.to = s.to + 7'd1;
        end
      end
    end
    if (n.st == 2'd1) n.own = 1'b0;
    else if (n.st == 2'd2) n.own = 1'b1;
    return n;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) m <= '{st: 2'd0, ls: 1'b1, own: 1'b0, cnt: 5'd0, to: 7'd0, err: 1'b0};
    else        m <= m_next(m, req0, req1, last0, last1, dn);
  end

  logic [1:0] exp_sel;
  always_comb begin
    exp_sel = 2'b00;
    if (m.st == 2'd1 && req0 && dn) exp_sel = 2'b01;
    else if (m.st == 2'd2 && req1 && dn) exp_sel = 2'b10;
  end

  // ---------------- mux model and payload sources ----------------
  logic [15:0] d0, d1, mux_seq;
  logic        mux_v, mux_src;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mux_v   <= 1'b0;
      mux_src <= 1'b0;
      mux_seq <= 16'd0;
      d0      <= 16'd0;
      d1      <= 16'd1000;
    end else begin
      mux_v   <= |sel_en;
      mux_src <= sel_en[1];
      mux_seq <= sel_en[1] ? d1 : d0;
      if (sel_en[0]) d0 <= d0 + 16'd1;
      if (sel_en[1]) d1 <= d1 + 16'd1;
    end
  end

  // ---------------- scoreboard and per-cycle monitor ----------------
  typedef struct packed {
    logic        v;
    logic        src;
    logic [15:0] seq;
  } sb_t;

  sb_t sb_q[$];
  sb_t sb_e;

  always @(negedge clk) begin
    if (!rst_n) begin
      sb_q.delete();
    end else begin
      if (sb_q.size() > 0) begin
        sb_e = sb_q.pop_front();
        checks++;
        if (mux_v !== sb_e.v || (sb_e.v && (mux_src !== sb_e.src || mux_seq !== sb_e.seq))) begin
          failures++;
          $display("FAIL sb_mux_out got v=%0b src=%0b seq=%0d exp v=%0b src=%0b seq=%0d",
                   mux_v, mux_src, mux_seq, sb_e.v, sb_e.src, sb_e.seq);
        end
      end
      sb_q.push_back('{v: (exp_sel != 2'b00), src: exp_sel[1], seq: (exp_sel[1] ? d1 : d0)});

      checks++;
      if (sel_en !== exp_sel) begin
        failures++;
        $display("FAIL mon_sel_en t=%0t got=%b exp=%b", $time, sel_en, exp_sel);
      end
      checks++;
      if (busy !== (m.st != 2'd0) || owner !== m.own) begin
        failures++;
        $display("FAIL mon_busy_owner t=%0t got busy=%b owner=%b exp busy=%b owner=%b",
                 $time, busy, owner, (m.st != 2'd0), m.own);
      end
      checks++;
      if (beat_cnt !== m.cnt || err !== m.err) begin
        failures++;
        $display("FAIL mon_cnt_err t=%0t got cnt=%0d err=%b exp cnt=%0d err=%b",
                 $time, beat_cnt, err, m.cnt, m.err);
      end
    end
  end

  // ---------------- helpers ----------------
  task automatic do_reset();
    rst_n = 1'b0;
    req0 = 1'b0; req1 = 1'b0; last0 = 1'b0; last1 = 1'b0; dn = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // ---------------- directed tests ----------------
  task automatic test_reset();
    do_reset();
    @(negedge clk);
    checks++;
    if (sel_en !== 2'b00 || busy !== 1'b0 || owner !== 1'b0 || beat_cnt !== '0 || err !== 1'b0) begin
      failures++;
      $display("FAIL reset_values got sel=%b busy=%b owner=%b cnt=%0d err=%b exp all zero",
               sel_en, busy, owner, beat_cnt, err);
    end
    step();
    req1 = 1'b1; dn = 1'b1;
    @(negedge clk);
    checks++;
    if (sel_en !== 2'b00) begin
      failures++;
      $display("FAIL arb_latency got=%b exp=00", sel_en);
    end
    step();
    step();
    step();
    checks++;
    if (sel_en !== 2'b10 || busy !== 1'b1 || owner !== 1'b1 || beat_cnt !== CW'(2)) begin
      failures++;
      $display("FAIL pre_reset_gnt1 got sel=%b busy=%b owner=%b cnt=%0d exp sel=10 busy=1 owner=1 cnt=2",
               sel_en, busy, owner, beat_cnt);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (sel_en !== 2'b00 || busy !== 1'b0 || beat_cnt !== '0 || owner !== 1'b0) begin
      failures++;
      $display("FAIL async_reset got sel=%b busy=%b cnt=%0d owner=%b exp sel=00 busy=0 cnt=0 owner=0",
               sel_en, busy, beat_cnt, owner);
    end
    req1 = 1'b0;
    step();
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || sel_en !== 2'b00) begin
      failures++;
      $display("FAIL post_reset_idle got busy=%b sel=%b exp busy=0 sel=00", busy, sel_en);
    end
  endtask

  task automatic test_tie();
    logic [1:0] exp_tbl [10];
    logic [1:0] a;
    int         b0, b1;
    exp_tbl = '{2'b00, 2'b01, 2'b01, 2'b01, 2'b01, 2'b10, 2'b10, 2'b10, 2'b10, 2'b01};
    do_reset();
    req0 = 1'b1; req1 = 1'b1; dn = 1'b1;
    b0 = 0; b1 = 0;
    for (int c = 0; c < 10; c++) begin
      last0 = (b0 == 3);
      last1 = (b1 == 3);
      @(negedge clk);
      checks++;
      if (sel_en !== exp_tbl[c]) begin
        failures++;
        $display("FAIL tie_order cycle=%0d got=%b exp=%b", c, sel_en, exp_tbl[c]);
      end
      a = sel_en;
      step();
      if (a[0]) b0 = (b0 + 1) % 4;
      if (a[1]) b1 = (b1 + 1) % 4;
    end
  endtask

  task automatic test_burst_cap();
    logic [1:0] exp;
    int         n_ack0;
    do_reset();
    req0 = 1'b1; req1 = 1'b1; dn = 1'b1; last0 = 1'b0; last1 = 1'b0;
    n_ack0 = 0;
    for (int c = 0; c < 18; c++) begin
      exp = (c == 0) ? 2'b00 : (c <= 16) ? 2'b01 : 2'b10;
      @(negedge clk);
      checks++;
      if (sel_en !== exp) begin
        failures++;
        $display("FAIL burst_cap_sel cycle=%0d got=%b exp=%b", c, sel_en, exp);
      end
      if (c == 16) begin
        checks++;
        if (beat_cnt !== CW'(15)) begin
          failures++;
          $display("FAIL burst_cap_cnt got=%0d exp=15", beat_cnt);
        end
      end
      if (ack0) n_ack0++;
      step();
    end
    checks++;
    if (n_ack0 != 16) begin
      failures++;
      $display("FAIL burst_cap_total got=%0d exp=16", n_ack0);
    end
  endtask

  task automatic test_back_pressure();
    do_reset();
    req0 = 1'b1; dn = 1'b1; last0 = 1'b0;
    repeat (3) step();
    dn = 1'b0;
    // Longer than the timeout: back-pressure must never count toward it.
    for (int c = 0; c < 70; c++) begin
      @(negedge clk);
      checks++;
      if (sel_en !== 2'b00 || err !== 1'b0 || beat_cnt !== CW'(2)) begin
        failures++;
        $display("FAIL back_pressure cycle=%0d got sel=%b err=%b cnt=%0d exp sel=00 err=0 cnt=2",
                 c, sel_en, err, beat_cnt);
      end
      step();
    end
    dn = 1'b1;
    @(negedge clk);
    checks++;
    if (sel_en !== 2'b01 || beat_cnt !== CW'(2)) begin
      failures++;
      $display("FAIL back_pressure_resume got sel=%b cnt=%0d exp sel=01 cnt=2", sel_en, beat_cnt);
    end
  endtask

  task automatic test_timeout();
    do_reset();
    req0 = 1'b1; dn = 1'b1; last0 = 1'b0;
    repeat (3) step();
    req0 = 1'b0;
    for (int c = 3; c <= 66; c++) begin
      if (c == 10) begin
        req1 = 1'b1; last1 = 1'b1;
      end
      @(negedge clk);
      checks++;
      if (err !== 1'b0 || sel_en !== 2'b00 || owner !== 1'b0) begin
        failures++;
        $display("FAIL timeout_wait cycle=%0d got err=%b sel=%b owner=%b exp err=0 sel=00 owner=0",
                 c, err, sel_en, owner);
      end
      step();
    end
    @(negedge clk);
    checks++;
    if (err !== 1'b1 || sel_en !== 2'b10 || owner !== 1'b1 || busy !== 1'b1) begin
      failures++;
      $display("FAIL timeout_fire got err=%b sel=%b owner=%b busy=%b exp err=1 sel=10 owner=1 busy=1",
               err, sel_en, owner, busy);
    end
    step();
    req1 = 1'b0; last1 = 1'b0;
    @(negedge clk);
    checks++;
    if (err !== 1'b0) begin
      failures++;
      $display("FAIL timeout_pulse_width got err=%b exp 0", err);
    end
  endtask

  task automatic test_random();
    logic a0, a1;
    int   p, beats, tos;
    do_reset();
    a0 = 1'b0; a1 = 1'b0; beats = 0; tos = 0;
    for (int c = 0; c < 10000; c++) begin
      p = (((c / 500) % 4) == 3) ? 2 : 70;
      if (!req0 || a0) begin
        req0  = ($urandom_range(0, 99) < p);
        last0 = ($urandom_range(0, 3) == 0);
      end
      if (!req1 || a1) begin
        req1  = ($urandom_range(0, 99) < p);
        last1 = ($urandom_range(0, 3) == 0);
      end
      dn = ($urandom_range(0, 4) != 0);
      @(negedge clk);
      checks++;
      if (sel_en === 2'b11 || {ack1, ack0} !== sel_en) begin
        failures++;
        $display("FAIL rand_onehot_ack cycle=%0d got sel=%b ack=%b%b exp one-hot-or-zero and equal",
                 c, sel_en, ack1, ack0);
      end
      checks++;
      if ((sel_en[0] && !(req0 && dn)) || (sel_en[1] && !(req1 && dn))) begin
        failures++;
        $display("FAIL rand_sel_legal cycle=%0d got sel=%b req=%b%b dn=%b", c, sel_en, req1, req0, dn);
      end
      a0 = ack0;
      a1 = ack1;
      if (|sel_en) beats++;
      if (err) tos++;
      step();
    end
    checks++;
    if (beats < 1000 || tos < 1) begin
      failures++;
      $display("FAIL rand_activity got beats=%0d timeouts=%0d exp beats>=1000 timeouts>=1", beats, tos);
    end
  endtask

  initial begin
    test_reset();
    test_tie();
    test_burst_cap();
    test_back_pressure();
    test_timeout();
    test_random();
    repeat (2) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
